// File: rtl/fxp_rescale_scheduler.sv
// fxp_rescale_scheduler
// Time-shared fixed-point rescaler. A round-robin arbiter picks one of
// NUM_CH requesters per cycle. A two-stage pipeline applies that channel's
// run-time binary-point shift, with optional saturation.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid and ready are both high. The producer keeps valid and data
// stable until the transfer. in_ready is a one-hot grant (or zero) that
// depends on in_valid, so a requester must not wait for in_ready before
// raising in_valid.
//
// Pipeline:
//   S1 - captured sample, channel, and the channel's shift/sat settings
//        as they stood at grant time.
//   S2 - result registers that drive out_data/out_ch/out_sat directly.
// Advance rule: adv2 = !out_valid | out_ready, adv1 = !s1_valid | adv2.

module fxp_rescale_scheduler #(
    parameter int NUM_CH      = 4,
    parameter int IN_WIDTH    = 16,
    parameter int OUT_WIDTH   = 16,
    parameter int SHIFT_WIDTH = 5,
    parameter int IS_SIGNED   = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,

    input  logic [NUM_CH-1:0]            in_valid,
    output logic [NUM_CH-1:0]            in_ready,
    input  logic [NUM_CH*IN_WIDTH-1:0]   in_data,

    input  logic                         cfg_we,
    input  logic [$clog2(NUM_CH)-1:0]    cfg_ch,
    input  logic [SHIFT_WIDTH-1:0]       cfg_shift,
    input  logic                         cfg_sat,

    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_WIDTH-1:0]         out_data,
    output logic [$clog2(NUM_CH)-1:0]    out_ch,
    output logic                         out_sat,

    output logic                         busy
);

    localparam int CH_W  = $clog2(NUM_CH);
    // Sixteen guard bits above the input hold any left shift of up to +15
    // without losing the sign, so overflow is detected exactly.
    localparam int INT_W = IN_WIDTH + 16;

    localparam logic [OUT_WIDTH-1:0] SMAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] SMIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [OUT_WIDTH-1:0] UMAX = {OUT_WIDTH{1'b1}};

    // ------------------------------------------------------------------
    // Per-channel configuration
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0][SHIFT_WIDTH-1:0] r_cfg_shift;
    logic [NUM_CH-1:0]                  r_cfg_sat;

    // ------------------------------------------------------------------
    // Arbiter / pipeline state
    // ------------------------------------------------------------------
    logic [CH_W-1:0]        r_ptr;

    logic                   r_s1_valid;
    logic [IN_WIDTH-1:0]    r_s1_data;
    logic [CH_W-1:0]        r_s1_ch;
    logic [SHIFT_WIDTH-1:0] r_s1_shift;
    logic                   r_s1_sat;

    logic                   r_out_valid;
    logic [OUT_WIDTH-1:0]   r_out_data;
    logic [CH_W-1:0]        r_out_ch;
    logic                   r_out_sat;

    logic                   w_adv1;
    logic                   w_adv2;

    logic [NUM_CH-1:0]      w_grant;
    logic                   w_grant_any;
    logic [CH_W-1:0]        w_grant_ch;
    logic [CH_W-1:0]        w_ptr_next;

    logic [IN_WIDTH-1:0]    w_sel_data;
    logic [SHIFT_WIDTH-1:0] w_sel_shift;
    logic                   w_sel_sat;

    logic                   w_sign_bit;
    logic [INT_W-1:0]       w_ext;
    logic signed [INT_W-1:0] w_ext_s;
    logic                   w_shift_neg;
    logic [SHIFT_WIDTH-1:0] w_shamt;
    logic [INT_W-1:0]       w_shifted;
    logic                   w_ovf;
    logic                   w_neg;
    logic [OUT_WIDTH-1:0]   w_res_data;
    logic                   w_res_sat;

    // Pipeline advance conditions
    assign w_adv2 = !r_out_valid || out_ready;
    assign w_adv1 = !r_s1_valid || w_adv2;

    // ------------------------------------------------------------------
    // Configuration registers: one write port, never stalls the pipeline.
    // A grant in the same cycle as a write sees the old value because S1
    // samples the register outputs, not the write data.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_CH; g++) begin : g_cfg
        // Hold shift/sat for channel g; update on a matching config write
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_cfg_shift[g] <= '0;
                r_cfg_sat[g]   <= 1'b0;
            end else if (cfg_we && (cfg_ch == CH_W'(g))) begin
                r_cfg_shift[g] <= cfg_shift;
                r_cfg_sat[g]   <= cfg_sat;
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter: first valid channel at or above r_ptr, wrapping.
    // Granting only when S1 can accept keeps in_ready a true acceptance.
    // ------------------------------------------------------------------
    // Scan requesters starting from the pointer and form the one-hot grant
    always_comb begin
        logic [CH_W-1:0] v_scan;
        v_scan      = '0;
        w_grant     = '0;
        w_grant_any = 1'b0;
        w_grant_ch  = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            v_scan = CH_W'((int'(r_ptr) + j) % NUM_CH);
            if (w_adv1 && !w_grant_any && in_valid[v_scan]) begin
                w_grant_any = 1'b1;
                w_grant_ch  = v_scan;
            end
        end
        if (w_grant_any) begin
            w_grant[w_grant_ch] = 1'b1;
        end
    end

    assign in_ready = w_grant;

    // Pointer moves to the channel after the winner, wrapping at NUM_CH
    assign w_ptr_next = (w_grant_ch == CH_W'(NUM_CH - 1)) ? '0
                                                          : w_grant_ch + CH_W'(1);

    // Mux the winner's sample and its current configuration
    assign w_sel_data  = in_data[w_grant_ch*IN_WIDTH +: IN_WIDTH];
    assign w_sel_shift = r_cfg_shift[w_grant_ch];
    assign w_sel_sat   = r_cfg_sat[w_grant_ch];

    // Round-robin pointer: advances only on a grant
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (w_grant_any) begin
            r_ptr <= w_ptr_next;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: capture the granted sample with its configuration snapshot
    // ------------------------------------------------------------------
    // Load S1 whenever it can advance; empties when nothing was granted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_ch    <= '0;
            r_s1_shift <= '0;
            r_s1_sat   <= 1'b0;
        end else if (w_adv1) begin
            r_s1_valid <= w_grant_any;
            if (w_grant_any) begin
                r_s1_data  <= w_sel_data;
                r_s1_ch    <= w_grant_ch;
                r_s1_shift <= w_sel_shift;
                r_s1_sat   <= w_sel_sat;
            end
        end
    end

    // ------------------------------------------------------------------
    // Rescale arithmetic on the S1 contents
    // ------------------------------------------------------------------
    assign w_sign_bit  = (IS_SIGNED != 0) ? r_s1_data[IN_WIDTH-1] : 1'b0;
    assign w_ext       = {{16{w_sign_bit}}, r_s1_data};
    assign w_ext_s     = w_ext;
    assign w_shift_neg = r_s1_shift[SHIFT_WIDTH-1];
    // Magnitude of the shift; -2^(SHIFT_WIDTH-1) maps to its unsigned value
    assign w_shamt     = w_shift_neg ? (~r_s1_shift + SHIFT_WIDTH'(1)) : r_s1_shift;

    // Left shift for positive amounts, arithmetic or logical right otherwise
    always_comb begin
        w_shifted = w_ext;
        if (!w_shift_neg) begin
            w_shifted = w_ext << w_shamt;
        end else if (IS_SIGNED != 0) begin
            w_shifted = w_ext_s >>> w_shamt;
        end else begin
            w_shifted = w_ext >> w_shamt;
        end
    end

    // Range check of the wide result against the OUT_WIDTH format
    always_comb begin
        w_neg = 1'b0;
        w_ovf = 1'b0;
        if (IS_SIGNED != 0) begin
            w_neg = w_shifted[INT_W-1];
            // In range only when every bit from the output sign bit upward agrees
            w_ovf = !((&w_shifted[INT_W-1:OUT_WIDTH-1]) ||
                      !(|w_shifted[INT_W-1:OUT_WIDTH-1]));
        end else begin
            w_ovf = |w_shifted[INT_W-1:OUT_WIDTH];
        end
    end

    // Clamp when saturation is enabled and the value does not fit, else wrap
    always_comb begin
        w_res_data = w_shifted[OUT_WIDTH-1:0];
        w_res_sat  = 1'b0;
        if (r_s1_sat && w_ovf) begin
            w_res_sat = 1'b1;
            if (IS_SIGNED != 0) begin
                w_res_data = w_neg ? SMIN : SMAX;
            end else begin
                w_res_data = UMAX;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: output registers; frozen while the consumer stalls
    // ------------------------------------------------------------------
    // Load the result when S2 can advance; outputs hold otherwise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_sat   <= 1'b0;
        end else if (w_adv2) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_res_data;
                r_out_ch   <= r_s1_ch;
                r_out_sat  <= w_res_sat;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_sat   = r_out_sat;
    assign busy      = r_s1_valid || r_out_valid;

endmodule

// File: doc/fxp_rescale_scheduler.md
Name: fxp_rescale_scheduler

Overview:
Time-shared fixed-point rescaling engine for NUM_CH requesters, such as DSP channels feeding a common DAC/FIFO path. A round-robin arbiter picks one requester per cycle. A 2-stage pipeline applies that channel's runtime-configured binary-point shift, with optional saturation. The block replaces per-channel static format converters when formats must change at run time.

Parameters:
NUM_CH, 4, number of requesters (>=2)
IN_WIDTH, 16, input sample width
OUT_WIDTH, 16, output sample width
SHIFT_WIDTH, 5, width of the signed shift field (range -16..+15)
IS_SIGNED, 1, 1 = two's-complement data (sign-extend / arithmetic shift), 0 = unsigned

Ports:
clk  in  1  sole clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  NUM_CH  per-channel sample valid
in_ready  out  NUM_CH  per-channel accept, one-hot or zero
in_data  in  NUM_CH*IN_WIDTH  packed samples, ch i at [i*IN_WIDTH +: IN_WIDTH]
cfg_we  in  1  config write strobe
cfg_ch  in  clog2(NUM_CH)  config target channel
cfg_shift  in  SHIFT_WIDTH  signed shift; >0 left, <0 right
cfg_sat  in  1  saturation enable for cfg_ch
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_data  out  OUT_WIDTH  rescaled sample
out_ch  out  clog2(NUM_CH)  source channel of out_data
out_sat  out  1  result was clamped
busy  out  1  any pipeline stage occupied

Behaviour:
- One clock. reset_n is asynchronous and active-low.
- Reset state: out_valid=0, out_data=0, out_ch=0, out_sat=0, busy=0, all stage valids 0, RR pointer=0, every channel's shift=0 and sat=0.
- Input transfer: a sample transfers on in_valid[i] & in_ready[i]. Output transfer: a result transfers on out_valid & out_ready.
- Pipeline: S1 holds the captured sample, channel and config. S2 holds the result registers that drive the outputs.
- Advance rule: adv2 = !out_valid | out_ready. adv1 = !s1_valid | adv2.
- Arbiter: when adv1 is high, it grants the first channel with in_valid set, scanning from the RR pointer upward with wrap. in_ready is the one-hot grant, a combinational function of in_valid, the pointer and adv1. When nothing is granted, in_ready=0.
- Pointer update: after a grant to channel k, the pointer becomes (k+1) mod NUM_CH. With no grant, the pointer holds.
- Latency: 2 cycles from input transfer to out_valid. Throughput is 1 sample/cycle with out_ready held high.
- Stall: when out_valid=1 and out_ready=0, out_data, out_ch and out_sat hold stable. S1 also holds if occupied, and in_ready goes all-zero.
- Config capture: the shift and sat values are latched into S1 at grant. A cfg write to channel k on the same cycle as a grant to k does not affect that sample; the new value applies to the next grant. Config writes never stall the pipeline.
- Arithmetic (S2):
  - Extend the input to an internal width of IN_WIDTH+16, using sign extension if IS_SIGNED, else zero extension.
  - Shift left by the shift value, or arithmetic/logical right by -shift. Right shifts truncate toward -inf (signed) or 0 (unsigned).
  - If sat=0, out_data is the low OUT_WIDTH bits (wrap) and out_sat=0.
  - If sat=1 and the result is outside the OUT_WIDTH range, clamp:
    - signed: to 2^(OUT_WIDTH-1)-1 or -2^(OUT_WIDTH-1)
    - unsigned: to 2^OUT_WIDTH-1
    - set out_sat=1.
- Edge cases:
  - shift=0 with IN_WIDTH=OUT_WIDTH passes data through unchanged.
  - shift=-16 yields 0 or all-ones (sign).
- Reset mid-operation: in-flight samples are discarded, out_valid drops immediately, and config returns to defaults.
- busy = s1_valid | out_valid.

Test Plan:
1. Defaults, ch0 in_data=0x1234, out_ready=1 -> 2 cycles later out_valid=1, out_data=0x1234, out_ch=0, out_sat=0.
2. cfg ch1 shift=-4 sat=0, ch1 0x1234 -> 0x0123. Then ch1 0x8001 -> 0xF800 (signed arithmetic right shift).
3. cfg ch2 shift=+4: sat=1 with 0x1234 -> 0x7FFF, out_sat=1. sat=1 with 0xE000 -> 0x8000, out_sat=1. sat=0 with 0x1234 -> 0x2340, out_sat=0.
4. All 4 in_valid held high for 8 cycles -> grant order 0,1,2,3,0,1,2,3, one per cycle. Drop ch1 valid -> order skips 1 without a lost cycle.
5. out_ready=0 for 5 cycles while all channels are valid -> the first result holds stable, in_ready=0 after S1 fills, no sample is lost or duplicated. On release, results arrive in grant order.
6. Two cases: (a) cfg write to ch3 (shift=-2) on the same cycle ch3 is granted with 0x0100 -> output 0x0100, and the next ch3 sample 0x0100 -> 0x0040. (b) Assert reset_n low while busy=1 -> out_valid=0 asynchronously, and after release the config is back to shift=0.
